// File: rtl/ulpi_rx_deframer_if.sv
// Bundle between the ULPI link RX side and the packet deframer.
// slave: deframer side (consumes RX CMD / data, drives status and packet beats).
// master: link/test side.
interface ulpi_rx_deframer_if #(
    parameter int unsigned LEN_W = 11
);
    logic [7:0]       rx_cmd;
    logic [7:0]       data;
    logic             data_valid;
    logic [1:0]       line_state;
    logic [1:0]       vbus_state;
    logic             id_dig;
    logic             host_disconnect;
    logic             rx_active;
    logic [7:0]       pkt_data;
    logic             pkt_valid;
    logic             pkt_sop;
    logic             pkt_eop;
    logic             pkt_err;
    logic [LEN_W-1:0] pkt_len;
    logic             rx_error;

    modport master (
        output rx_cmd, data, data_valid,
        input  line_state, vbus_state, id_dig, host_disconnect, rx_active,
        input  pkt_data, pkt_valid, pkt_sop, pkt_eop, pkt_err, pkt_len, rx_error
    );

    modport slave (
        input  rx_cmd, data, data_valid,
        output line_state, vbus_state, id_dig, host_disconnect, rx_active,
        output pkt_data, pkt_valid, pkt_sop, pkt_eop, pkt_err, pkt_len, rx_error
    );
endinterface

// File: rtl/ulpi_rx_deframer.sv
// ULPI receive deframer: decodes RX CMD status and frames received bytes into
// sop/eop-marked packet beats with length and error flags.
// Optional feature: define ULPI_RX_PID_CHECK_EN to flag a malformed PID byte.
module ulpi_rx_deframer #(
    parameter int unsigned MAX_LEN = 1027,
    parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
    input logic               clk,
    input logic               reset,
    ulpi_rx_deframer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    state_t           state;
    logic [7:0]       hold_data;
    logic             hold_vld;
    logic             hold_first;
    logic [LEN_W-1:0] count;
    logic             err;
    logic             ovf;
    logic             prev_ev_hi;

    logic [1:0] ev;
    logic       at_max;
    logic       take;
    logic       drop;
    logic       pid_bad;
    logic       err_now;
    logic       unused_cmd_bit;

    // RxEvent field and byte acceptance qualifiers for the ACTIVE state.
    assign ev             = bus.rx_cmd[5:4];
    assign at_max         = (count == LEN_W'(MAX_LEN));
    assign take           = bus.data_valid && !at_max;
    assign drop           = bus.data_valid && at_max;
    assign unused_cmd_bit = bus.rx_cmd[7];

`ifdef ULPI_RX_PID_CHECK_EN
    // PID byte must carry its check nibble (low nibble = inverted high nibble).
    assign pid_bad = take && (count == '0) && (bus.data[3:0] != ~bus.data[7:4]);
`else
    assign pid_bad = 1'b0;
`endif

    // Packet error as it stands including anything detected this cycle.
    assign err_now = err || (ev == 2'b11) || drop || pid_bad;

    // Status decode, one cycle behind rx_cmd; rx_error fires on entry into 11 from 00/01.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.line_state      <= 2'b00;
            bus.vbus_state      <= 2'b00;
            bus.id_dig          <= 1'b0;
            bus.host_disconnect <= 1'b0;
            bus.rx_error        <= 1'b0;
            prev_ev_hi          <= 1'b0;
        end else begin
            bus.line_state      <= bus.rx_cmd[1:0];
            bus.vbus_state      <= bus.rx_cmd[3:2];
            bus.id_dig          <= bus.rx_cmd[6];
            bus.host_disconnect <= (ev == 2'b10);
            bus.rx_error        <= (ev == 2'b11) && !prev_ev_hi;
            prev_ev_hi          <= ev[1];
        end
    end

    // Framing FSM: each byte waits in the hold register until its successor or the packet end.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            hold_data     <= 8'h00;
            hold_vld      <= 1'b0;
            hold_first    <= 1'b0;
            count         <= '0;
            err           <= 1'b0;
            ovf           <= 1'b0;
            bus.rx_active <= 1'b0;
            bus.pkt_data  <= 8'h00;
            bus.pkt_valid <= 1'b0;
            bus.pkt_sop   <= 1'b0;
            bus.pkt_eop   <= 1'b0;
            bus.pkt_err   <= 1'b0;
            bus.pkt_len   <= '0;
        end else begin
            bus.pkt_valid <= 1'b0;
            bus.pkt_sop   <= 1'b0;
            bus.pkt_eop   <= 1'b0;
            bus.pkt_err   <= 1'b0;
            bus.pkt_len   <= '0;
            case (state)
                IDLE: begin
                    if (ev[0]) begin
                        state         <= ACTIVE;
                        bus.rx_active <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (take) begin
                        if (hold_vld) begin
                            bus.pkt_data  <= hold_data;
                            bus.pkt_valid <= 1'b1;
                            bus.pkt_sop   <= hold_first;
                        end
                        hold_data  <= bus.data;
                        hold_vld   <= 1'b1;
                        hold_first <= (count == '0);
                        count      <= count + LEN_W'(1);
                    end
                    if (ev[0] || take) begin
                        // Still receiving, or a last byte arrived with the end: it drains next cycle.
                        err <= err_now;
                        ovf <= ovf || drop;
                        if (!ev[0]) begin
                            state <= DRAIN;
                        end
                    end else begin
                        if (hold_vld) begin
                            bus.pkt_data  <= hold_data;
                            bus.pkt_valid <= 1'b1;
                            bus.pkt_sop   <= hold_first;
                            bus.pkt_eop   <= 1'b1;
                            bus.pkt_err   <= err_now;
                            bus.pkt_len   <= count;
                        end
                        hold_vld      <= 1'b0;
                        hold_first    <= 1'b0;
                        count         <= '0;
                        err           <= 1'b0;
                        ovf           <= 1'b0;
                        state         <= IDLE;
                        bus.rx_active <= 1'b0;
                    end
                end
                DRAIN: begin
                    bus.pkt_data  <= hold_data;
                    bus.pkt_valid <= hold_vld;
                    bus.pkt_sop   <= hold_first;
                    bus.pkt_eop   <= 1'b1;
                    bus.pkt_err   <= err;
                    bus.pkt_len   <= count;
                    hold_vld      <= 1'b0;
                    hold_first    <= 1'b0;
                    count         <= '0;
                    err           <= 1'b0;
                    ovf           <= 1'b0;
                    state         <= IDLE;
                    bus.rx_active <= 1'b0;
                end
                default: begin
                    state         <= IDLE;
                    bus.rx_active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ulpi_rx_deframer.sv
// Randomized self-checking bench for ulpi_rx_deframer against a packet-level model.
module tb_ulpi_rx_deframer;

    localparam int unsigned MAX_LEN = 4;
    localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1);

    typedef struct packed {
        logic [7:0]       data;
        logic             sop;
        logic             eop;
        logic             err;
        logic [LEN_W-1:0] len;
    } beat_t;

    logic clk = 1'b0;
    logic reset;

    ulpi_rx_deframer_if #(.LEN_W(LEN_W)) bus ();

    ulpi_rx_deframer #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  stim[$];
    beat_t       exp_q[$];
    beat_t       got_q[$];
    beat_t       mon_b;
    int          err_pulses = 0;

    // Capture every emitted beat and every rx_error pulse.
    always @(negedge clk) begin
        if (bus.pkt_valid) begin
            mon_b.data = bus.pkt_data;
            mon_b.sop  = bus.pkt_sop;
            mon_b.eop  = bus.pkt_eop;
            mon_b.err  = bus.pkt_err;
            mon_b.len  = bus.pkt_len;
            got_q.push_back(mon_b);
        end
        if (bus.rx_error) err_pulses++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Packet-level model: first MAX_LEN bytes survive; error from RxError, overflow or bad PID.
    task automatic build_expect(input bit rxerr);
        int         n;
        int         k;
        bit         e;
        logic [7:0] pid;
        beat_t      b;
        n = stim.size();
        k = (n > int'(MAX_LEN)) ? int'(MAX_LEN) : n;
        e = rxerr || (n > int'(MAX_LEN));
`ifdef ULPI_RX_PID_CHECK_EN
        if (n > 0) begin
            pid = stim[0];
            if (pid[3:0] != ~pid[7:4]) e = 1'b1;
        end
`else
        pid = 8'h00;
`endif
        exp_q.delete();
        for (int i = 0; i < k; i++) begin
            b.data = stim[i];
            b.sop  = (i == 0);
            b.eop  = (i == k - 1);
            b.err  = b.eop ? e : 1'b0;
            b.len  = b.eop ? LEN_W'(k) : '0;
            exp_q.push_back(b);
        end
    endtask

    task automatic compare_pkt(input string name);
        int m;
        check_eq({name, "_nbeats"}, got_q.size(), exp_q.size());
        m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < m; i++) begin
            check_eq($sformatf("%s_data%0d", name, i), got_q[i].data, exp_q[i].data);
            check_eq($sformatf("%s_sop%0d", name, i), got_q[i].sop, exp_q[i].sop);
            check_eq($sformatf("%s_eop%0d", name, i), got_q[i].eop, exp_q[i].eop);
            if (exp_q[i].eop) begin
                check_eq({name, "_err"}, got_q[i].err, exp_q[i].err);
                check_eq({name, "_len"}, got_q[i].len, exp_q[i].len);
            end
        end
    endtask

    // Drive one packet from stim; err_slot>=0 inserts one RxError cycle before that byte index.
    task automatic send_pkt(input string name, input int err_slot, input bit drain, input bit gaps);
        int n;
        bit drain_eff;
        n = stim.size();
        drain_eff = drain && (n > 0);
        got_q.delete();
        err_pulses = 0;
        build_expect(err_slot >= 0);
        bus.rx_cmd     = 8'h10;
        bus.data_valid = 1'b0;
        @(negedge clk);
        check_eq({name, "_rx_active_on"}, bus.rx_active, 1);
        for (int i = 0; i <= n; i++) begin
            if (i == err_slot) begin
                bus.rx_cmd     = 8'h30;
                bus.data_valid = 1'b0;
                @(negedge clk);
                bus.rx_cmd = 8'h10;
            end
            if (i == n) break;
            if (gaps && ($urandom_range(0, 2) == 0)) begin
                bus.data_valid = 1'b0;
                @(negedge clk);
            end
            bus.data       = stim[i];
            bus.data_valid = 1'b1;
            if (drain_eff && (i == n - 1)) bus.rx_cmd = 8'h00;
            @(negedge clk);
        end
        bus.data_valid = 1'b0;
        if (!drain_eff) begin
            bus.rx_cmd = 8'h00;
            @(negedge clk);
            check_eq({name, "_eop_latency"}, bus.pkt_valid && bus.pkt_eop, (n > 0) ? 1 : 0);
        end
        bus.rx_cmd = 8'h00;
        repeat (4) @(negedge clk);
        check_eq({name, "_rx_active_off"}, bus.rx_active, 0);
        compare_pkt(name);
        check_eq({name, "_rx_error_pulses"}, err_pulses, (err_slot >= 0) ? 1 : 0);
    endtask

    initial begin
        int         n;
        int         es;
        bit         dr;
        logic [7:0] v;

        reset          = 1'b1;
        bus.rx_cmd     = 8'h00;
        bus.data       = 8'h00;
        bus.data_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_pkt_valid", bus.pkt_valid, 0);
        check_eq("rst_pkt_len", bus.pkt_len, 0);
        check_eq("rst_rx_active", bus.rx_active, 0);
        check_eq("rst_status", {bus.line_state, bus.vbus_state, bus.id_dig, bus.host_disconnect, bus.rx_error}, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Directed packets.
        stim = '{8'hC3, 8'h01, 8'h02};
        send_pkt("basic3", -1, 1'b0, 1'b0);
        stim = '{8'hD2};
        send_pkt("single", -1, 1'b0, 1'b0);
        stim = '{8'h4B, 8'hAA};
        send_pkt("rxerr", 2, 1'b0, 1'b0);
        stim = '{8'hC3, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        send_pkt("ovf", -1, 1'b0, 1'b0);
        stim = '{8'hC4, 8'h10};
        send_pkt("pid", -1, 1'b0, 1'b0);
        stim = '{8'hC3, 8'h5A, 8'hA5};
        send_pkt("drain", -1, 1'b1, 1'b0);
        stim = '{8'hD2};
        send_pkt("drain1", -1, 1'b1, 1'b0);
        stim = '{8'hC3, 8'h01, 8'h02, 8'h03};
        send_pkt("at_max", -1, 1'b0, 1'b0);
        stim.delete();
        send_pkt("zero_len", -1, 1'b0, 1'b0);

        // Status decode with no packet activity.
        bus.rx_cmd = 8'h2D;
        @(negedge clk);
        check_eq("st2d_line", bus.line_state, 1);
        check_eq("st2d_vbus", bus.vbus_state, 3);
        check_eq("st2d_hdisc", bus.host_disconnect, 1);
        check_eq("st2d_id", bus.id_dig, 0);
        check_eq("st2d_pkt_valid", bus.pkt_valid, 0);
        for (int i = 0; i < 16; i++) begin
            v = 8'($urandom_range(0, 255)) & 8'hEF;
            bus.rx_cmd = v;
            @(negedge clk);
            check_eq("strnd_line", bus.line_state, v[1:0]);
            check_eq("strnd_vbus", bus.vbus_state, v[3:2]);
            check_eq("strnd_id", bus.id_dig, v[6]);
            check_eq("strnd_hdisc", bus.host_disconnect, (v[5:4] == 2'b10) ? 1 : 0);
            check_eq("strnd_valid", bus.pkt_valid, 0);
        end
        bus.rx_cmd = 8'h00;
        repeat (2) @(negedge clk);

        // Reset in the middle of a packet discards it.
        got_q.delete();
        bus.rx_cmd = 8'h1F;
        @(negedge clk);
        bus.data = 8'hC3; bus.data_valid = 1'b1;
        @(negedge clk);
        bus.data = 8'h77;
        @(negedge clk);
        bus.data_valid = 1'b0;
        reset = 1'b1;
        #1;
        check_eq("mrst_status", {bus.line_state, bus.vbus_state, bus.id_dig, bus.host_disconnect}, 0);
        check_eq("mrst_pkt", {bus.pkt_valid, bus.pkt_sop, bus.pkt_eop, bus.pkt_err, bus.rx_active}, 0);
        check_eq("mrst_len", bus.pkt_len, 0);
        bus.rx_cmd = 8'h00;
        got_q.delete();
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("mrst_no_beats", got_q.size(), 0);

        // Randomized packets.
        for (int p = 0; p < 40; p++) begin
            n = $urandom_range(0, 7);
            stim.delete();
            for (int i = 0; i < n; i++) stim.push_back(8'($urandom_range(0, 255)));
            dr = ($urandom_range(0, 2) == 0);
            es = -1;
            if ($urandom_range(0, 3) == 0) es = $urandom_range(0, (dr && n > 0) ? n - 1 : n);
            send_pkt($sformatf("rnd%0d", p), es, dr, ($urandom_range(0, 1) == 1));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
